// File: rtl/mem_access_if.sv
// Data-memory port of the SELEN memory-stage access unit.
// Single-beat request/acknowledge bus.
//   master (mem_access): drives dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be;
//                        receives dmem_ack and dmem_rdata.
//   slave  (memory):     the reverse directions.
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// mem_access: memory-stage load/store unit of the SELEN core.
// Converts the registered memory-stage command into one request/acknowledge
// transaction on the data-memory port. It steers store bytes onto lanes and
// aligns plus sign/zero-extends load data. It stalls the memory-stage register
// while the access is outstanding.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   addrM, srcbM      byte address and store data
//   be_memM           size: 00 byte, 01 half, 10 word, 11 illegal
//   we_memM, ld_memM  store / load command (store wins)
//   sx_2M_ctrl        bit0: 1 sign-extend, 0 zero-extend
//   flashM            memory-stage flush
//   stall_memM        hold request for the memory-stage register
//   ldataM, ldata_vldM     extended load result and its one-cycle valid
//   misalign_errM     one-cycle misaligned/illegal access flag
//   bus_errM          one-cycle acknowledge-timeout flag
//   dmem              data-memory port (mem_access_if.master)
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to enable an acknowledge
// watchdog of TIMEOUT cycles. Without it, WAIT lasts until dmem_ack and
// bus_errM is tied to 0.
module mem_access #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        addrM,
  input  logic [31:0]        srcbM,
  input  logic [1:0]         be_memM,
  input  logic               we_memM,
  input  logic               ld_memM,
  input  logic [2:0]         sx_2M_ctrl,
  input  logic               flashM,
  output logic               stall_memM,
  output logic [31:0]        ldataM,
  output logic               ldata_vldM,
  output logic               misalign_errM,
  output logic               bus_errM,
  mem_access_if.master       dmem
);

  if (TIMEOUT < 1) begin : gTimeoutCheck
    $error("mem_access: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic        weR, sxR, dropR, timedOut;
  logic [1:0]  sizeR, lowAddr;
  logic [31:0] addrR, wdataR, ldataR;
  logic [3:0]  beR;

  logic        cmd, misaligned, accept;
  logic [31:0] laneWdata, shifted, extData;
  logic [3:0]  laneBe;
  logic        unusedSxBits;

  assign unusedSxBits = ^sx_2M_ctrl[2:1];

  assign cmd        = we_memM | ld_memM;
  assign misaligned = (be_memM == 2'b11) ||
                      (be_memM == 2'b01 && addrM[0]) ||
                      (be_memM == 2'b10 && addrM[1:0] != 2'b00);
  // Gated by rst_n so that every output is 0 while reset is held.
  assign accept        = rst_n && state == IDLE && cmd && !flashM && !misaligned;
  assign misalign_errM = rst_n && state == IDLE && cmd && !flashM && misaligned;
  assign stall_memM    = accept || state == WAIT;

  always_comb begin
    laneWdata = srcbM;
    laneBe    = 4'b1111;
    case (be_memM)
      2'b00: begin
        laneWdata = {4{srcbM[7:0]}};
        laneBe    = 4'b0001 << addrM[1:0];
      end
      2'b01: begin
        laneWdata = {2{srcbM[15:0]}};
        laneBe    = 4'b0011 << {addrM[1], 1'b0};
      end
      default: ;
    endcase
  end

  // For halves lowAddr[0] is 0, so the same byte shift serves all sizes.
  always_comb begin
    shifted = dmem.dmem_rdata >> {lowAddr, 3'b000};
    case (sizeR)
      2'b00:   extData = {{24{sxR & shifted[7]}}, shifted[7:0]};
      2'b01:   extData = {{16{sxR & shifted[15]}}, shifted[15:0]};
      default: extData = shifted;
    endcase
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      weR      <= 1'b0;
      sxR      <= 1'b0;
      dropR    <= 1'b0;
      timedOut <= 1'b0;
      sizeR    <= '0;
      lowAddr  <= '0;
      addrR    <= '0;
      wdataR   <= '0;
      beR      <= '0;
      ldataR   <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= WAIT;
            weR      <= we_memM;
            sxR      <= sx_2M_ctrl[0];
            sizeR    <= be_memM;
            lowAddr  <= addrM[1:0];
            addrR    <= {addrM[31:2], 2'b00};
            wdataR   <= laneWdata;
            beR      <= laneBe;
            dropR    <= 1'b0;
            timedOut <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt      <= '0;
`endif
          end
        end
        WAIT: begin
          // The request is never withdrawn on flush; only the result is dropped.
          if (flashM) dropR <= 1'b1;
          if (dmem.dmem_ack) begin
            state <= DONE;
            if (!weR) ldataR <= extData;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            state    <= DONE;
            timedOut <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = (state == WAIT);
  assign dmem.dmem_we    = weR;
  assign dmem.dmem_addr  = addrR;
  assign dmem.dmem_wdata = wdataR;
  assign dmem.dmem_be    = beR;

  assign ldataM     = ldataR;
  assign ldata_vldM = state == DONE && !weR && !dropR && !timedOut && !flashM;

`ifdef MEM_ACCESS_TIMEOUT_EN
  assign bus_errM = state == DONE && timedOut;
`else
  assign bus_errM = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  localparam int TMO = 4;
`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] addrM = '0, srcbM = '0;
  logic [1:0]  be_memM = '0;
  logic        we_memM = 1'b0, ld_memM = 1'b0, flashM = 1'b0;
  logic [2:0]  sx_2M_ctrl = '0;
  logic        stall_memM, ldata_vldM, misalign_errM, bus_errM;
  logic [31:0] ldataM;

  mem_access_if bus ();

  mem_access #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .addrM(addrM), .srcbM(srcbM), .be_memM(be_memM),
    .we_memM(we_memM), .ld_memM(ld_memM), .sx_2M_ctrl(sx_2M_ctrl), .flashM(flashM),
    .stall_memM(stall_memM), .ldataM(ldataM), .ldata_vldM(ldata_vldM),
    .misalign_errM(misalign_errM), .bus_errM(bus_errM), .dmem(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, vld, merr, berr, req, we;
    logic [31:0] ldata, addr, wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t e;
  int   nChecks = 0, nErrors = 0;
  int   stallCycles, reqCycles, vldCount, errCount, berrCount;
  logic [31:0] capAddr, capWdata, capLdata;
  logic [3:0]  capBe;
  logic        capWe;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int nBytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] mBe(input logic [31:0] a, input logic [1:0] sz);
    int v;
    v = ((1 << nBytes(sz)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] mWdata(input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nBytes(sz)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mLoad(input logic [31:0] rd, input logic [31:0] a,
                                        input logic [1:0] sz, input logic sx);
    logic [31:0] v, mask;
    int bits;
    bits = 8 * nBytes(sz);
    v    = rd >> (8 * (a % 4));
    mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'h1 << bits) - 1);
    v    = v & mask;
    if (sx && bits < 32 && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic exp_t zeroExp();
    exp_t z;
    z.stall = 0; z.vld = 0; z.merr = 0; z.berr = 0; z.req = 0; z.we = 0;
    z.ldata = '0; z.addr = '0; z.wdata = '0; z.be = '0;
    return z;
  endfunction

  // Single compare process: every cycle, outputs against the expected record.
  always @(negedge clk) begin
    chk("stall", {31'd0, stall_memM}, {31'd0, e.stall});
    chk("ldata_vld", {31'd0, ldata_vldM}, {31'd0, e.vld});
    chk("misalign", {31'd0, misalign_errM}, {31'd0, e.merr});
    chk("bus_err", {31'd0, bus_errM}, {31'd0, e.berr});
    chk("req", {31'd0, bus.dmem_req}, {31'd0, e.req});
    if (e.req) begin
      chk("we", {31'd0, bus.dmem_we}, {31'd0, e.we});
      chk("addr", bus.dmem_addr, e.addr);
      chk("be", {28'd0, bus.dmem_be}, {28'd0, e.be});
      if (e.we) chk("wdata", bus.dmem_wdata, e.wdata);
    end
    if (e.vld) chk("ldata", ldataM, e.ldata);
    if (stall_memM) stallCycles++;
    if (bus.dmem_req) begin
      reqCycles++;
      capAddr = bus.dmem_addr; capWdata = bus.dmem_wdata; capBe = bus.dmem_be; capWe = bus.dmem_we;
    end
    if (ldata_vldM) begin vldCount++; capLdata = ldataM; end
    if (misalign_errM) errCount++;
    if (bus_errM) berrCount++;
  end

  task automatic endCycle();
    @(posedge clk); #1;
  endtask

  task automatic clearCounts();
    stallCycles = 0; reqCycles = 0; vldCount = 0; errCount = 0; berrCount = 0;
  endtask

  task automatic idleInputs();
    we_memM = 0; ld_memM = 0; flashM = 0; bus.dmem_ack = 0;
  endtask

  // One command from the memory stage, including its whole transaction.
  // waits < 0: never acknowledge (only meaningful with the watchdog).
  task automatic access(input logic [31:0] a, d, input logic [1:0] sz, input logic w, l, sx,
                        input int waits, input logic flush0, input int flushAt,
                        input logic flushDone, input logic [31:0] rd);
    logic bad, dropped, tmo, isLoad;
    addrM = a; srcbM = d; be_memM = sz; we_memM = w; ld_memM = l;
    sx_2M_ctrl = {$urandom_range(0, 3), sx}; flashM = flush0;
    bus.dmem_ack = 0; bus.dmem_rdata = $urandom;
    bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    isLoad = !w;
    e = zeroExp();
    if (!(w || l) || flush0) begin endCycle(); idleInputs(); e = zeroExp(); return; end
    if (bad) begin e.merr = 1; endCycle(); idleInputs(); e = zeroExp(); return; end
    e.stall = 1;
    endCycle();
    dropped = 0; tmo = 0;
    for (int k = 0; ; k++) begin
      e = zeroExp();
      e.req = 1; e.stall = 1; e.we = w; e.addr = {a[31:2], 2'b00};
      e.be = mBe(a, sz); e.wdata = mWdata(d, sz);
      flashM = (k == flushAt);
      if (k == flushAt) dropped = 1;
      bus.dmem_ack = (k == waits);
      bus.dmem_rdata = (k == waits) ? rd : $urandom;
      endCycle();
      if (k == waits) break;
      if (TO_EN && k == TMO - 1) begin tmo = 1; break; end
      if (k > 60) begin chk("wait_bound", 32'd1, 32'd0); break; end
    end
    bus.dmem_ack = 0; flashM = flushDone; bus.dmem_rdata = $urandom;
    e = zeroExp();
    e.berr = tmo;
    e.vld = isLoad && !dropped && !tmo && !flushDone;
    e.ldata = mLoad(rd, a, sz, sx);
    endCycle();
    idleInputs();
    e = zeroExp();
  endtask

  initial begin
    e = zeroExp();
    bus.dmem_ack = 0; bus.dmem_rdata = '0;
    clearCounts();
    #2 rst_n = 0;
    #1;
    chk("rst_stall", {31'd0, stall_memM}, 32'd0);
    chk("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_addr", bus.dmem_addr, 32'd0);
    chk("rst_ldata", ldataM, 32'd0);
    chk("rst_vld", {31'd0, ldata_vldM}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    endCycle();

    // Word store, zero wait states.
    clearCounts();
    access(32'h100, 32'hDEADBEEF, 2'd2, 1, 0, 0, 0, 0, -1, 0, 32'h0);
    chk("tp_wst_addr", capAddr, 32'h100);
    chk("tp_wst_be", {28'd0, capBe}, 32'hF);
    chk("tp_wst_wdata", capWdata, 32'hDEADBEEF);
    chk("tp_wst_we", {31'd0, capWe}, 32'd1);
    chk("tp_wst_stall", stallCycles, 32'd2);
    chk("tp_wst_vld", vldCount, 32'd0);

    // Byte load, sign- and zero-extended.
    clearCounts();
    access(32'h203, 32'h0, 2'd0, 0, 1, 1, 0, 0, -1, 0, 32'h80FF_1234);
    chk("tp_bld_sx", capLdata, 32'hFFFFFF80);
    chk("tp_bld_be", {28'd0, capBe}, 32'h8);
    chk("tp_bld_vld", vldCount, 32'd1);
    chk("tp_bld_req", reqCycles, 32'd1);
    clearCounts();
    access(32'h203, 32'h0, 2'd0, 0, 1, 0, 0, 0, -1, 0, 32'h80FF_1234);
    chk("tp_bld_zx", capLdata, 32'h00000080);

    // Half store lane replication.
    clearCounts();
    access(32'h12, 32'h0000ABCD, 2'd1, 1, 0, 0, 1, 0, -1, 0, 32'h0);
    chk("tp_hst_wdata", capWdata, 32'hABCDABCD);
    chk("tp_hst_be", {28'd0, capBe}, 32'hC);
    chk("tp_hst_addr", capAddr, 32'h10);

    // Misaligned word load.
    clearCounts();
    access(32'h102, 32'h0, 2'd2, 0, 1, 0, 0, 0, -1, 0, 32'h0);
    chk("tp_mis_err", errCount, 32'd1);
    chk("tp_mis_req", reqCycles, 32'd0);
    chk("tp_mis_stall", stallCycles, 32'd0);

    // Load with three wait states, flushed in the first WAIT cycle.
    clearCounts();
    access(32'h40, 32'h0, 2'd2, 0, 1, 0, 3, 0, 0, 0, 32'h1234_5678);
    chk("tp_flush_req", reqCycles, 32'd4);
    chk("tp_flush_vld", vldCount, 32'd0);
    chk("tp_flush_stall", stallCycles, 32'd5);

    // Acknowledge outside WAIT is ignored.
    bus.dmem_ack = 1; e = zeroExp(); endCycle(); bus.dmem_ack = 0;

`ifdef MEM_ACCESS_TIMEOUT_EN
    clearCounts();
    access(32'h80, 32'h0, 2'd2, 0, 1, 0, -1, 0, -1, 0, 32'h0);
    chk("tp_tmo_req", reqCycles, TMO);
    chk("tp_tmo_berr", berrCount, 32'd1);
    chk("tp_tmo_vld", vldCount, 32'd0);
`endif

    // Reset mid-WAIT, then a late acknowledge.
    addrM = 32'h300; be_memM = 2'd2; ld_memM = 1; we_memM = 0;
    e = zeroExp(); e.stall = 1;
    endCycle();
    e = zeroExp(); e.req = 1; e.stall = 1; e.addr = 32'h300; e.be = 4'hF;
    endCycle();
    rst_n = 0; e = zeroExp();
    #1;
    chk("mid_rst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall_memM}, 32'd0);
    chk("mid_rst_addr", bus.dmem_addr, 32'd0);
    chk("mid_rst_be", {28'd0, bus.dmem_be}, 32'd0);
    chk("mid_rst_we", {31'd0, bus.dmem_we}, 32'd0);
    chk("mid_rst_wdata", bus.dmem_wdata, 32'd0);
    chk("mid_rst_ldata", ldataM, 32'd0);
    idleInputs();
    bus.dmem_ack = 1;
    endCycle();
    rst_n = 1;
    endCycle();
    bus.dmem_ack = 0;
    endCycle();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, d, rd;
      logic [1:0] sz;
      logic w, l, sx, f0, fd;
      int waits, fAt;
      a  = $urandom; d = $urandom; rd = $urandom;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'd0;
      w  = 1'($urandom_range(0, 1));
      l  = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      f0 = ($urandom_range(0, 9) == 0);
      fd = ($urandom_range(0, 5) == 0);
      waits = $urandom_range(0, 3);
      fAt = ($urandom_range(0, 4) == 0) ? $urandom_range(0, waits) : -1;
      access(a, d, sz, w, l, sx, waits, f0, fAt, fd, rd);
      if ($urandom_range(0, 7) == 0) begin
        bus.dmem_ack = 1; e = zeroExp(); endCycle(); bus.dmem_ack = 0;
      end
    end

    endCycle();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage access unit of the SELEN core, sitting directly downstream of the memory-stage pipeline register. It turns the registered load/store command (address, store data, size, sign control) into a single-beat request/acknowledge transaction on the data-memory port. It performs byte-lane steering for stores and alignment plus sign/zero extension for loads. While a transaction is outstanding it holds the memory-stage register via a stall output.

## Interface
Parameters:
- TIMEOUT, 64, acknowledge watchdog limit in cycles; used only when MEM_ACCESS_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- addrM  in  32  byte address from the memory-stage register.
- srcbM  in  32  store data.
- be_memM  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- we_memM  in  1  store command.
- ld_memM  in  1  load command; we_memM has priority if both are set.
- sx_2M_ctrl  in  3  bit0 = 1 sign-extend, 0 zero-extend; bits 2:1 ignored.
- flashM  in  1  flush of the memory stage.
- stall_memM  out  1  hold request to the memory-stage register (drives enbM).
- ldataM  out  32  extended load result.
- ldata_vldM  out  1  one-cycle pulse, ldataM valid.
- misalign_errM  out  1  one-cycle misaligned/illegal access flag.
- bus_errM  out  1  one-cycle timeout flag.
- dmem_req  out  1  request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word address, {addr[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  acknowledge, single cycle.
- dmem_rdata  in  32  read data, valid with dmem_ack.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset puts the FSM in IDLE and drives every output to 0.
- IDLE, no command (or flashM = 1): stay in IDLE, stall_memM = 0.
- IDLE, command present and misaligned/illegal:
  - Misaligned/illegal means: half with addr[0] = 1, word with addr[1:0] != 0, or size 11.
  - misalign_errM = 1 combinationally, no bus request, stall_memM = 0, stay in IDLE.
- IDLE, command present and aligned:
  - stall_memM = 1 combinationally.
  - Latch we, size, sx, addr[1:0], dmem_addr, dmem_wdata and dmem_be.
  - Next state is WAIT.
- WAIT:
  - dmem_req = 1 and stall_memM = 1.
  - All dmem_* outputs stay stable until dmem_ack.
  - On dmem_ack, go to DONE and register the extracted load data.
- DONE:
  - stall_memM = 0, so the memory-stage register advances at the end of this cycle.
  - For loads that were not dropped, ldata_vldM = 1. For stores, ldata_vldM = 0.
  - Inputs are ignored in DONE, because the old command is still present. Return to IDLE.
- Store lanes:
  - byte: wdata = {4{srcb[7:0]}}, be = 4'b0001 << addr[1:0].
  - half: wdata = {2{srcb[15:0]}}, be = 4'b0011 << {addr[1],1'b0}.
  - word: wdata = srcb, be = 4'b1111.
- Load extraction: select the byte or half by the latched addr[1:0], then sign- or zero-extend to 32 bits per sx bit0.
- Loads also drive dmem_be with the access lanes.
- Flush during WAIT:
  - The request is not withdrawn; it stays until dmem_ack.
  - A drop flag is set, so the following DONE suppresses ldata_vldM.
- Flush in DONE: suppress ldata_vldM.

## Timing
- Minimum access: command visible at cycle 0 → dmem_req from cycle 1 → ack at cycle 1 → ldata_vldM at cycle 2. Throughput is one access per 3 cycles.
- Each extra wait cycle adds 1 cycle of latency and 1 cycle of stall.
- stall_memM is high from cycle 0 through the ack cycle, and low in DONE.
- ldataM holds its value until the next load completes.
- Reset asserted mid-transaction: immediate return to IDLE with dmem_req = 0. A late dmem_ack is ignored.
- dmem_ack outside WAIT is ignored.

## Configuration
- MEM_ACCESS_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without an ack: drop dmem_req, pulse bus_errM in DONE, and hold ldata_vldM = 0.
- MEM_ACCESS_TIMEOUT_EN undefined: WAIT lasts indefinitely and bus_errM is tied to 0. The port is always present.

## Test plan
- Word store, addr = 0x100, srcb = 0xDEADBEEF, ack after 0 waits:
  - dmem_addr = 0x100, be = 1111, wdata = 0xDEADBEEF, dmem_we = 1.
  - stall_memM high for 2 cycles, ldata_vldM never set.
- Byte load, addr = 0x203, rdata = 0x80FF_1234:
  - With sx = 1: ldataM = 0xFFFFFF80.
  - With sx = 0: ldataM = 0x00000080.
  - be = 1000, ldata_vldM pulses at cycle 2.
- Half store, addr = 0x12, srcb = 0x0000ABCD: wdata = 0xABCDABCD, be = 1100.
- Word load at addr = 0x102: misalign_errM = 1 for 1 cycle, no dmem_req, stall_memM = 0.
- Load with 3 wait states and flashM pulsed in the first WAIT cycle:
  - dmem_req held 4 cycles, DONE reached, ldata_vldM = 0.
- With MEM_ACCESS_TIMEOUT_EN and TIMEOUT = 4, no ack:
  - dmem_req drops after 4 WAIT cycles, bus_errM pulses once, FSM returns to IDLE.
  - Also assert rst_n low mid-WAIT: all outputs go to 0 at once.
